// File: rtl/uart_bridge_pkg.sv
// uart_bridge_pkg
// Shared definitions for the UART bridge: TX sequencer state encoding and the
// default FIFO geometry / TX pacing constants used as parameter defaults.
package uart_bridge_pkg;

  localparam int DEF_RX_AW  = 8;   // RX FIFO depth 256
  localparam int DEF_TX_AW  = 4;   // TX FIFO depth 16
  localparam int DEF_TX_GAP = 4;   // minimum clk cycles between tx_wr pulses

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/dpram.sv
// dpram
// Simple dual-port RAM: one write port, one synchronous read port.
// A read of the address being written in the same cycle returns the old word.
// Ports:
//   clk        - clock, rising edge
//   i_wr_en    - write enable
//   i_wr_addr  - write address
//   i_wr_data  - write data
//   i_rd_addr  - read address, sampled every cycle
//   o_rd_data  - registered read data (one cycle after i_rd_addr)
module dpram #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 i_wr_en,
  input  logic [ADDRWIDTH-1:0] i_wr_addr,
  input  logic [DATAWIDTH-1:0] i_wr_data,
  input  logic [ADDRWIDTH-1:0] i_rd_addr,
  output logic [DATAWIDTH-1:0] o_rd_data
);

  logic [DATAWIDTH-1:0] r_mem [0:(1<<ADDRWIDTH)-1];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/uart_bridge.sv
// uart_bridge
// Bridges a byte stream from an MCU link into a host-readable RX FIFO, and a
// host-written TX FIFO out to the MCU usb_uart_tx_wr path with paced strobes.
//
// Ports:
//   clk, reset_n            - clock (rising edge), async active-low reset
//   rx_data, rx_idx         - incoming byte; a new byte is present whenever
//                             rx_idx differs from the last index seen
//   mcu_busy                - while high, no new TX transfer is started
//   host_rd, host_clr       - pop strobe, flush strobe (single cycle)
//   host_dout, rx_count     - RX head byte (0 while rx_avail=0), occupancy
//   rx_avail                - head byte on host_dout is valid
//   rx_overflow, rx_lost    - sticky: byte dropped on full / index gap seen
//   host_wr, host_din       - TX push strobe and byte
//   tx_free, tx_drop        - free TX entries, sticky TX-full drop
//   tx_data, tx_wr          - byte and single-cycle strobe toward the MCU
//   o_tx_state              - TX sequencer state (debug)
//
// Strobe semantics: host_rd pops only in a cycle where rx_avail=1 (otherwise
// ignored); host_wr pushes whenever the TX FIFO is not full (otherwise the
// byte is dropped and tx_drop set); host_clr wins over any push/pop in the
// same cycle. tx_wr is a one-cycle strobe with no back-pressure.
module uart_bridge
  import uart_bridge_pkg::*;
#(
  parameter int RX_AW  = DEF_RX_AW,
  parameter int TX_AW  = DEF_TX_AW,
  parameter int TX_GAP = DEF_TX_GAP
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [7:0]     rx_data,
  input  logic [7:0]     rx_idx,
  input  logic           mcu_busy,
  input  logic           host_rd,
  input  logic           host_clr,
  output logic [7:0]     host_dout,
  output logic [RX_AW:0] rx_count,
  output logic           rx_avail,
  output logic           rx_overflow,
  output logic           rx_lost,
  input  logic           host_wr,
  input  logic [7:0]     host_din,
  output logic [TX_AW:0] tx_free,
  output logic           tx_drop,
  output logic [7:0]     tx_data,
  output logic           tx_wr,
  output logic [1:0]     o_tx_state
);

  localparam logic [RX_AW:0] RX_ONE     = {{RX_AW{1'b0}}, 1'b1};
  localparam logic [TX_AW:0] TX_ONE     = {{TX_AW{1'b0}}, 1'b1};
  localparam logic [TX_AW:0] TX_DEPTH_W = {1'b1, {TX_AW{1'b0}}};
  localparam logic [7:0]     GAP_LOAD   = 8'(TX_GAP - 1);

  // ---------------------------------------------------------------- RX side
  logic           r_primed;
  logic [7:0]     r_prev_idx;
  logic [RX_AW:0] r_rx_wp;
  logic [RX_AW:0] r_rx_rp;
  logic           r_rx_avail;
  logic           r_rx_ovf;
  logic           r_rx_lost;

  logic [RX_AW:0] w_rx_count;
  logic           w_rx_full;
  logic           w_rx_new;
  logic           w_rx_gap;
  logic           w_rx_push;
  logic           w_rx_pop;
  logic [7:0]     w_ram_q;

  // Pointers carry one extra bit so full (MSB of the difference) and empty
  // are distinguishable; occupancy can never exceed the depth.
  assign w_rx_count = r_rx_wp - r_rx_rp;
  assign w_rx_full  = w_rx_count[RX_AW];
  assign w_rx_new   = r_primed && (rx_idx != r_prev_idx);
  assign w_rx_gap   = w_rx_new && (rx_idx != (r_prev_idx + 8'd1));
  assign w_rx_push  = w_rx_new && !w_rx_full && !host_clr;
  assign w_rx_pop   = host_rd && r_rx_avail && !host_clr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_primed   <= 1'b0;
      r_prev_idx <= 8'h00;
      r_rx_wp    <= '0;
      r_rx_rp    <= '0;
      r_rx_avail <= 1'b0;
      r_rx_ovf   <= 1'b0;
      r_rx_lost  <= 1'b0;
    end else begin
      r_primed <= 1'b1;
      // The index is tracked even across a flush so the next byte is not
      // mistaken for a gap or a duplicate.
      if (!r_primed || w_rx_new) r_prev_idx <= rx_idx;
      if (host_clr) begin
        r_rx_wp    <= '0;
        r_rx_rp    <= '0;
        r_rx_avail <= 1'b0;
        r_rx_ovf   <= 1'b0;
        r_rx_lost  <= 1'b0;
      end else begin
        if (w_rx_push) r_rx_wp <= r_rx_wp + RX_ONE;
        if (w_rx_pop)  r_rx_rp <= r_rx_rp + RX_ONE;
        if (w_rx_new && w_rx_full) r_rx_ovf <= 1'b1;
        if (w_rx_gap) r_rx_lost <= 1'b1;
        // The RAM output registers mem[rd_ptr] on this same edge, so the head
        // is valid exactly when entries were already committed before it.
        // After a pop the head is stale for one cycle while it is refetched.
        r_rx_avail <= (w_rx_count != '0) && !w_rx_pop;
      end
    end
  end

  dpram #(
    .DATAWIDTH (8),
    .ADDRWIDTH (RX_AW)
  ) u_rx_ram (
    .clk       (clk),
    .i_wr_en   (w_rx_push),
    .i_wr_addr (r_rx_wp[RX_AW-1:0]),
    .i_wr_data (rx_data),
    .i_rd_addr (r_rx_rp[RX_AW-1:0]),
    .o_rd_data (w_ram_q)
  );

  assign host_dout   = r_rx_avail ? w_ram_q : 8'h00;
  assign rx_avail    = r_rx_avail;
  assign rx_count    = w_rx_count;
  assign rx_overflow = r_rx_ovf;
  assign rx_lost     = r_rx_lost;

  // ---------------------------------------------------------------- TX side
  logic [7:0]     r_tx_mem [0:(1<<TX_AW)-1];
  logic [TX_AW:0] r_tx_wp;
  logic [TX_AW:0] r_tx_rp;
  logic           r_tx_drop;
  tx_state_t      r_state;
  tx_state_t      w_next;
  logic [7:0]     r_gap_cnt;
  logic [7:0]     w_gap_nxt;
  logic           w_send;

  logic [TX_AW:0] w_tx_count;
  logic           w_tx_full;
  logic           w_tx_ready;
  logic           w_tx_push;
  logic           w_tx_pop;
  logic [7:0]     w_tx_head;

  assign w_tx_count = r_tx_wp - r_tx_rp;
  assign w_tx_full  = w_tx_count[TX_AW];
  // A flush in the deciding cycle must not launch a SEND on an empty FIFO.
  assign w_tx_ready = (w_tx_count != '0) && !mcu_busy && !host_clr;
  assign w_tx_push  = host_wr && !w_tx_full && !host_clr;
  assign w_tx_pop   = w_send && !host_clr;
  assign w_tx_head  = r_tx_mem[r_tx_rp[TX_AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp[TX_AW-1:0]] <= host_din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_wp   <= '0;
      r_tx_rp   <= '0;
      r_tx_drop <= 1'b0;
      r_state   <= S_IDLE;
      r_gap_cnt <= 8'h00;
    end else begin
      r_state   <= w_next;
      r_gap_cnt <= w_gap_nxt;
      if (host_clr) begin
        r_tx_wp   <= '0;
        r_tx_rp   <= '0;
        r_tx_drop <= 1'b0;
      end else begin
        if (w_tx_push) r_tx_wp <= r_tx_wp + TX_ONE;
        if (w_tx_pop)  r_tx_rp <= r_tx_rp + TX_ONE;
        if (host_wr && w_tx_full) r_tx_drop <= 1'b1;
      end
    end
  end

  // Pacing: SEND loads TX_GAP-1, GAP counts down. When the count reaches 0
  // the sequencer may start the next SEND directly, so back-to-back pulses
  // are exactly TX_GAP cycles apart (2 at minimum, the SEND+decide loop).
  always_comb begin
    w_next    = r_state;
    w_gap_nxt = r_gap_cnt;
    w_send    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_tx_ready) w_next = S_SEND;
      end
      S_SEND: begin
        w_send    = 1'b1;
        w_gap_nxt = GAP_LOAD;
        w_next    = (TX_GAP > 1) ? S_GAP : S_IDLE;
      end
      S_GAP: begin
        if (r_gap_cnt > 8'd1) begin
          w_gap_nxt = r_gap_cnt - 8'd1;
        end else begin
          w_gap_nxt = 8'h00;
          w_next    = w_tx_ready ? S_SEND : S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign tx_wr      = w_send;
  assign tx_data    = w_send ? w_tx_head : 8'h00;
  assign tx_free    = TX_DEPTH_W - w_tx_count;
  assign tx_drop    = r_tx_drop;
  assign o_tx_state = r_state;

endmodule

// File: tb/tb_uart_bridge.sv
// Directed bench for uart_bridge: RX table vectors, RX fill/drain, TX pacing,
// busy blocking and reset mid-gap.
module tb_uart_bridge;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] rx_data, rx_idx;
  logic       mcu_busy, host_rd, host_clr;
  logic [7:0] host_dout;
  logic [8:0] rx_count;
  logic       rx_avail, rx_overflow, rx_lost;
  logic       host_wr;
  logic [7:0] host_din;
  logic [4:0] tx_free;
  logic       tx_drop;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic [1:0] tx_state;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_d[$];
  int         obs_t[$];

  uart_bridge #(.RX_AW(8), .TX_AW(4), .TX_GAP(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx_data     (rx_data),
    .rx_idx      (rx_idx),
    .mcu_busy    (mcu_busy),
    .host_rd     (host_rd),
    .host_clr    (host_clr),
    .host_dout   (host_dout),
    .rx_count    (rx_count),
    .rx_avail    (rx_avail),
    .rx_overflow (rx_overflow),
    .rx_lost     (rx_lost),
    .host_wr     (host_wr),
    .host_din    (host_din),
    .tx_free     (tx_free),
    .tx_drop     (tx_drop),
    .tx_data     (tx_data),
    .tx_wr       (tx_wr),
    .o_tx_state  (tx_state)
  );

  // ---------------------------------------------------- clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // tx_wr monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (tx_wr === 1'b1) begin
      obs_d.push_back(tx_data);
      obs_t.push_back(cyc);
    end
  end

  // ---------------------------------------------------- driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------- RX vector table
  typedef struct {
    logic [7:0] idx;
    logic [7:0] data;
    logic       rd;
    logic       clr;
    logic [8:0] cnt;
    logic       avail;
    logic [7:0] dout;
    logic       lost;
    logic       ovf;
  } vec_t;

  vec_t vt[21];

  initial begin
    //         idx    data   rd    clr   cnt    avail dout   lost  ovf
    vt[0]  = '{8'd0,  8'h00, 1'b0, 1'b0, 9'd0, 1'b0, 8'h00, 1'b0, 1'b0}; // priming
    vt[1]  = '{8'd1,  8'h41, 1'b0, 1'b0, 9'd1, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[2]  = '{8'd1,  8'h41, 1'b0, 1'b0, 9'd1, 1'b1, 8'h41, 1'b0, 1'b0};
    vt[3]  = '{8'd2,  8'h42, 1'b0, 1'b0, 9'd2, 1'b1, 8'h41, 1'b0, 1'b0};
    vt[4]  = '{8'd2,  8'h42, 1'b1, 1'b0, 9'd1, 1'b0, 8'h00, 1'b0, 1'b0}; // pop
    vt[5]  = '{8'd2,  8'h42, 1'b1, 1'b0, 9'd1, 1'b1, 8'h42, 1'b0, 1'b0}; // rd ignored
    vt[6]  = '{8'd2,  8'h42, 1'b1, 1'b0, 9'd0, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[7]  = '{8'd2,  8'h42, 1'b0, 1'b0, 9'd0, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[8]  = '{8'd5,  8'h55, 1'b0, 1'b0, 9'd1, 1'b0, 8'h00, 1'b1, 1'b0}; // gap 2->5
    vt[9]  = '{8'd5,  8'h55, 1'b0, 1'b0, 9'd1, 1'b1, 8'h55, 1'b1, 1'b0};
    vt[10] = '{8'd5,  8'h55, 1'b0, 1'b1, 9'd0, 1'b0, 8'h00, 1'b0, 1'b0}; // clr
    vt[11] = '{8'd5,  8'h55, 1'b0, 1'b0, 9'd0, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[12] = '{8'd6,  8'h60, 1'b0, 1'b0, 9'd1, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[13] = '{8'd7,  8'h61, 1'b0, 1'b0, 9'd2, 1'b1, 8'h60, 1'b0, 1'b0};
    vt[14] = '{8'd8,  8'h62, 1'b0, 1'b0, 9'd3, 1'b1, 8'h60, 1'b0, 1'b0};
    vt[15] = '{8'd9,  8'h63, 1'b1, 1'b0, 9'd3, 1'b0, 8'h00, 1'b0, 1'b0}; // push+pop
    vt[16] = '{8'd9,  8'h63, 1'b0, 1'b0, 9'd3, 1'b1, 8'h61, 1'b0, 1'b0};
    vt[17] = '{8'd10, 8'h64, 1'b0, 1'b1, 9'd0, 1'b0, 8'h00, 1'b0, 1'b0}; // clr+push
    vt[18] = '{8'd10, 8'h64, 1'b1, 1'b0, 9'd0, 1'b0, 8'h00, 1'b0, 1'b0}; // rd on empty
    vt[19] = '{8'd11, 8'h70, 1'b0, 1'b0, 9'd1, 1'b0, 8'h00, 1'b0, 1'b0}; // prev kept
    vt[20] = '{8'd11, 8'h70, 1'b0, 1'b1, 9'd0, 1'b0, 8'h00, 1'b0, 1'b0};
  end

  // ---------------------------------------------------- main sequence
  initial begin
    int w;
    int t_wr;
    reset_n  = 1'b0;
    rx_data  = 8'h00;
    rx_idx   = 8'h00;
    mcu_busy = 1'b0;
    host_rd  = 1'b0;
    host_clr = 1'b0;
    host_wr  = 1'b0;
    host_din = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset rx_count", rx_count, 0);
    chk("reset rx_avail", rx_avail, 0);
    chk("reset host_dout", host_dout, 0);
    chk("reset rx_overflow", rx_overflow, 0);
    chk("reset rx_lost", rx_lost, 0);
    chk("reset tx_free", tx_free, 16);
    chk("reset tx_drop", tx_drop, 0);
    chk("reset tx_wr", tx_wr, 0);
    chk("reset tx_data", tx_data, 0);
    chk("reset state", tx_state, 0);
    reset_n = 1'b1;

    // RX table
    for (int i = 0; i < 21; i++) begin
      rx_idx   = vt[i].idx;
      rx_data  = vt[i].data;
      host_rd  = vt[i].rd;
      host_clr = vt[i].clr;
      tick();
      host_rd  = 1'b0;
      host_clr = 1'b0;
      chk($sformatf("v%0d rx_count", i), rx_count, vt[i].cnt);
      chk($sformatf("v%0d rx_avail", i), rx_avail, vt[i].avail);
      chk($sformatf("v%0d host_dout", i), host_dout, vt[i].dout);
      chk($sformatf("v%0d rx_lost", i), rx_lost, vt[i].lost);
      chk($sformatf("v%0d rx_overflow", i), rx_overflow, vt[i].ovf);
    end

    // RX full: 257 pushes, last one dropped
    for (int i = 0; i < 257; i++) begin
      rx_idx  = 8'(12 + i);
      rx_data = 8'(i);
      if (i < 256) exp_q.push_back(8'(i));
      tick();
    end
    chk("full rx_count", rx_count, 256);
    chk("full rx_overflow", rx_overflow, 1);
    chk("full rx_lost", rx_lost, 0);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] e;
      w = 0;
      while (rx_avail !== 1'b1 && w < 4) begin
        tick();
        w++;
      end
      e = exp_q.pop_front();
      chk($sformatf("drain %0d host_dout", i), host_dout, e);
      host_rd = 1'b1;
      tick();
      host_rd = 1'b0;
    end
    tick();
    chk("drained rx_count", rx_count, 0);
    chk("drained rx_overflow sticky", rx_overflow, 1);

    // TX pacing: three back-to-back writes
    t_wr = cyc;
    host_wr = 1'b1;
    host_din = 8'h10; exp_q.push_back(8'h10);
    tick();
    chk("tx_free after 1 write", tx_free, 15);
    host_din = 8'h11; exp_q.push_back(8'h11);
    tick();
    chk("tx_free after 2 writes", tx_free, 14);
    host_din = 8'h12; exp_q.push_back(8'h12);
    tick();
    chk("tx_free write+pop", tx_free, 14);
    host_wr = 1'b0;
    w = 0;
    while (obs_d.size() < 3 && w < 40) begin
      tick();
      w++;
    end
    repeat (8) tick();
    chk("pace pulse count", obs_d.size(), 3);
    if (obs_d.size() == 3) begin
      for (int i = 0; i < 3; i++) chk($sformatf("pace data %0d", i), obs_d[i], exp_q.pop_front());
      chk("pace spacing 0-1", obs_t[1] - obs_t[0], 4);
      chk("pace spacing 1-2", obs_t[2] - obs_t[1], 4);
      chk("first tx_wr latency in 2..3", (obs_t[0] - t_wr >= 2) && (obs_t[0] - t_wr <= 3), 1);
    end
    chk("tx_free drained", tx_free, 16);

    // Busy: fill 16, 17th dropped, no pulses while busy
    mcu_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      host_wr  = 1'b1;
      host_din = 8'h20 + 8'(i);
      tick();
    end
    chk("tx_free full", tx_free, 0);
    chk("tx_drop before overflow", tx_drop, 0);
    host_din = 8'hEE;
    tick();
    host_wr = 1'b0;
    chk("tx_drop on 17th", tx_drop, 1);
    chk("tx_free still 0", tx_free, 0);
    repeat (10) tick();
    chk("no tx_wr while busy", obs_d.size(), 3);
    for (int i = 0; i < 3; i++) exp_q.push_back(8'h20 + 8'(i));
    mcu_busy = 1'b0;
    w = 0;
    while (obs_d.size() < 6 && w < 40) begin
      tick();
      w++;
    end
    chk("resumed pulse count", obs_d.size(), 6);
    chk("in GAP before reset", tx_state, 2);
    if (obs_d.size() == 6) begin
      for (int i = 3; i < 6; i++) chk($sformatf("resume data %0d", i), obs_d[i], exp_q.pop_front());
      chk("resume spacing", obs_t[5] - obs_t[4], 4);
    end

    // Reset mid-GAP
    reset_n = 1'b0;
    #1;
    chk("mid-gap reset tx_free", tx_free, 16);
    chk("mid-gap reset tx_drop", tx_drop, 0);
    chk("mid-gap reset state", tx_state, 0);
    chk("mid-gap reset tx_wr", tx_wr, 0);
    tick();
    tick();
    reset_n = 1'b1;
    repeat (30) tick();
    chk("no tx_wr after reset", obs_d.size(), 6);
    chk("tx_free after reset", tx_free, 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_bridge.md
UART_BRIDGE -- requirements
Module: uart_bridge

Interface
REQ-001 SHALL have parameter RX_AW, default 8, RX FIFO address width (depth 256).
REQ-002 SHALL have parameter TX_AW, default 4, TX FIFO address width (depth 16).
REQ-003 SHALL have parameter TX_GAP, default 4, minimum clk cycles between tx_wr pulses (range 1..255).
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports rx_data/rx_idx, input, 8/8, byte and running index from the MCU link; rx_data is valid when rx_idx changes.
REQ-007 SHALL have port mcu_busy, input, 1, MCU init in progress; blocks TX.
REQ-008 SHALL have ports host_rd/host_clr, input, 1/1, single-cycle pop strobe and flush strobe.
REQ-009 SHALL have ports host_dout/rx_count, output, 8/RX_AW+1, head byte and RX occupancy.
REQ-010 SHALL have ports rx_avail/rx_overflow/rx_lost, output, 1/1/1, head valid, sticky RX-full drop, sticky index gap.
REQ-011 SHALL have ports host_wr/host_din, input, 1/8, single-cycle TX push strobe and byte.
REQ-012 SHALL have ports tx_free/tx_drop, output, TX_AW+1/1, free TX entries and sticky TX-full drop.
REQ-013 SHALL have ports tx_data/tx_wr, output, 8/1, byte and single-cycle strobe toward the MCU usb_uart_tx_wr path.

Function
REQ-014 RX capture: the first clk after reset SHALL load prev_idx <= rx_idx without pushing; thereafter rx_idx != prev_idx SHALL push rx_data in that cycle and update prev_idx.
REQ-015 A push where rx_idx != prev_idx+1 (mod 256) SHALL still store the byte and set rx_lost.
REQ-016 Push with rx_count == 2^RX_AW SHALL drop the byte, set rx_overflow, and leave the pointers unchanged.
REQ-017 The RX FIFO SHALL use synchronous-read RAM; host_dout SHALL show the head byte and rx_avail SHALL assert at most 2 cycles after a push into an empty FIFO.
REQ-018 host_rd with rx_avail=1 SHALL advance the read pointer; rx_avail SHALL drop for exactly 1 cycle while the next head is fetched; host_rd with rx_avail=0 SHALL be ignored.
REQ-019 Simultaneous push and pop SHALL leave rx_count unchanged.
REQ-020 rx_count SHALL equal pushes minus pops, with wrap-around of the pointers modulo depth.
REQ-021 host_clr SHALL empty both FIFOs and clear rx_overflow, rx_lost and tx_drop; a push or pop in the same cycle SHALL be discarded; clr SHALL NOT reset prev_idx.
REQ-022 TX: host_wr SHALL push host_din; if the FIFO is full it SHALL drop the byte and set tx_drop; tx_free = depth - occupancy.
REQ-023 The TX FSM SHALL have states IDLE, SEND, GAP.
REQ-024 TX FSM transitions:
- IDLE->SEND when the FIFO is non-empty and mcu_busy=0.
- SEND: tx_wr=1 for one cycle, tx_data=head, pop, gap counter <= TX_GAP-1, ->GAP (->IDLE if TX_GAP=1).
- GAP: decrement the counter; ->IDLE at 0.
REQ-025 mcu_busy rising while in GAP SHALL not abort the gap; no SEND SHALL start while mcu_busy=1.
REQ-026 Simultaneous host_wr and SEND pop SHALL keep tx_free unchanged; host_wr into an empty FIFO SHALL yield tx_wr no earlier than 2 cycles later.

Reset
REQ-027 reset_n low SHALL asynchronously set:
- all pointers, counts and sticky flags to 0;
- rx_avail=0, host_dout=0, tx_wr=0, tx_data=0;
- tx_free=2^TX_AW;
- FSM=IDLE and the priming flag clear.
REQ-028 Reset asserted mid-transfer SHALL discard the FIFO contents with no further tx_wr pulses; RAM contents need not be cleared.

Structure
REQ-029 The shared package uart_bridge_pkg SHALL hold the TX state enum and default RX_AW/TX_AW/TX_GAP constants.
REQ-030 RX storage SHALL instantiate the existing dpram (DATAWIDTH 8, ADDRWIDTH RX_AW).
REQ-031 TX storage SHALL be a register array inside uart_bridge.
REQ-032 No other sub-module SHALL be used.

Verification
REQ-033 The bench SHALL cover RX basic: after priming, idx 0->1->2 with data 0x41, 0x42 -> rx_count=2; two host_rd -> host_dout 0x41 then 0x42; rx_count=0; rx_lost=0.
REQ-034 The bench SHALL cover index gap: idx 2->5 with data 0x55 -> byte stored, rx_lost=1; host_clr -> rx_lost=0, rx_count=0.
REQ-035 The bench SHALL cover RX full: 257 pushes without reads -> rx_count=256, rx_overflow=1; 256 reads return the first 256 bytes in order.
REQ-036 The bench SHALL cover simultaneous events: push and host_rd in the same cycle at rx_count=3 -> rx_count stays 3; host_clr with push in the same cycle -> rx_count=0.
REQ-037 The bench SHALL cover TX pacing: with TX_GAP=4, write 0x10, 0x11, 0x12 back-to-back -> three tx_wr pulses exactly 4 cycles apart carrying 0x10, 0x11, 0x12; a 17th write into a full FIFO -> tx_drop=1.
REQ-038 The bench SHALL cover busy and reset: mcu_busy=1 with 2 bytes queued -> no tx_wr; busy released -> pulses resume; reset_n pulsed mid-GAP -> tx_free=16, no tx_wr afterwards.
